// File: rtl/pkt_size_queues.sv
// Bank of per-queue packet-size FIFOs feeding a deficit round-robin scheduler.
// Optional per-queue full-drop counters are built when PKT_QS_DROP_CNT_EN is defined.
module pkt_size_queues #(
  parameter int  PKT_QS_CNT = 4,
  parameter int  FIFO_DEPTH = 8,
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1,
  localparam int QW         = (PKT_QS_CNT > 1) ? $clog2(PKT_QS_CNT) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [QW-1:0]                    wr_q_i,
  input  logic [15:0]                      wr_size_i,
  input  logic                             wr_val_i,
  output logic                             wr_ready_o,
  input  logic [QW-1:0]                    read_i,
  input  logic                             read_val_i,
  output logic [PKT_QS_CNT-1:0][15:0]      size_o,
  output logic [PKT_QS_CNT-1:0]            size_val_o,
  output logic [PKT_QS_CNT-1:0][CNT_W-1:0] level_o,
  output logic [PKT_QS_CNT-1:0][15:0]      drop_cnt_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [PW-1:0]    wr_ptr_q [PKT_QS_CNT];
  logic [PW-1:0]    wr_ptr_d [PKT_QS_CNT];
  logic [PW-1:0]    rd_ptr_q [PKT_QS_CNT];
  logic [PW-1:0]    rd_ptr_d [PKT_QS_CNT];
  logic [CNT_W-1:0] cnt_q    [PKT_QS_CNT];
  logic [CNT_W-1:0] cnt_d    [PKT_QS_CNT];
  logic [15:0]      mem_q    [PKT_QS_CNT][FIFO_DEPTH];

  logic                  wr_full;
  logic                  wr_fire;
  logic                  rd_fire;
  logic [PKT_QS_CNT-1:0] wr_hit;
  logic [PKT_QS_CNT-1:0] rd_hit;

  // Full is judged on the current occupancy only, so a same-cycle pop never rescues a write.
  assign wr_full    = (cnt_q[wr_q_i] == CNT_W'(FIFO_DEPTH));
  assign wr_ready_o = !wr_full;
  assign wr_fire    = wr_val_i && !wr_full && (wr_size_i != 16'd0);
  assign rd_fire    = read_val_i && (cnt_q[read_i] != '0);
  assign wr_hit     = wr_fire ? (PKT_QS_CNT'(1) << wr_q_i) : '0;
  assign rd_hit     = rd_fire ? (PKT_QS_CNT'(1) << read_i) : '0;

  // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
  always_comb begin
    for (int q = 0; q < PKT_QS_CNT; q++) begin
      wr_ptr_d[q] = wr_ptr_q[q];
      rd_ptr_d[q] = rd_ptr_q[q];
      cnt_d[q]    = cnt_q[q];
      if (wr_hit[q]) wr_ptr_d[q] = wr_ptr_q[q] + PW'(1);
      if (rd_hit[q]) rd_ptr_d[q] = rd_ptr_q[q] + PW'(1);
      case ({wr_hit[q], rd_hit[q]})
        2'b10:   cnt_d[q] = cnt_q[q] + CNT_W'(1);
        2'b01:   cnt_d[q] = cnt_q[q] - CNT_W'(1);
        default: cnt_d[q] = cnt_q[q];
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all queues update from the same pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int q = 0; q < PKT_QS_CNT; q++) begin
        wr_ptr_q[q] <= '0;
        rd_ptr_q[q] <= '0;
        cnt_q[q]    <= '0;
      end
    end else begin
      for (int q = 0; q < PKT_QS_CNT; q++) begin
        wr_ptr_q[q] <= wr_ptr_d[q];
        rd_ptr_q[q] <= rd_ptr_d[q];
        cnt_q[q]    <= cnt_d[q];
      end
    end
  end

  // NOTE: the size storage has no reset; empty queues gate their head to 0, so stale contents never escape.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_q_i][wr_ptr_q[wr_q_i]] <= wr_size_i;
  end

  for (genvar q = 0; q < PKT_QS_CNT; q++) begin : g_out
    assign size_val_o[q] = (cnt_q[q] != '0);
    assign level_o[q]    = cnt_q[q];
    assign size_o[q]     = size_val_o[q] ? mem_q[q][rd_ptr_q[q]] : 16'd0;
  end

`ifdef PKT_QS_DROP_CNT_EN
  logic                       wr_drop_full;
  logic [PKT_QS_CNT-1:0][15:0] drop_cnt_q;

  // Zero-size writes are rejected silently; only full-queue drops are counted.
  assign wr_drop_full = wr_val_i && wr_full;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      drop_cnt_q <= '0;
    end else begin
      for (int q = 0; q < PKT_QS_CNT; q++) begin
        if (wr_drop_full && (wr_q_i == QW'(q)) && (drop_cnt_q[q] != 16'hFFFF))
          drop_cnt_q[q] <= drop_cnt_q[q] + 16'd1;
      end
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pkt_size_queues.sv
// Directed bench for pkt_size_queues: vector table plus hand sequences for
// full/drop, mid-operation reset and a deficit round-robin style drain.
module tb_pkt_size_queues;

  localparam int NQ = 4;
  localparam int CW = 4;

  logic                  clk_i;
  logic                  rst_i;
  logic [1:0]            wr_q_i;
  logic [15:0]           wr_size_i;
  logic                  wr_val_i;
  logic                  wr_ready_o;
  logic [1:0]            read_i;
  logic                  read_val_i;
  logic [NQ-1:0][15:0]   size_o;
  logic [NQ-1:0]         size_val_o;
  logic [NQ-1:0][CW-1:0] level_o;
  logic [NQ-1:0][15:0]   drop_cnt_o;

  pkt_size_queues #(.PKT_QS_CNT(NQ), .FIFO_DEPTH(8)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_q_i     (wr_q_i),
    .wr_size_i  (wr_size_i),
    .wr_val_i   (wr_val_i),
    .wr_ready_o (wr_ready_o),
    .read_i     (read_i),
    .read_val_i (read_val_i),
    .size_o     (size_o),
    .size_val_o (size_val_o),
    .level_o    (level_o),
    .drop_cnt_o (drop_cnt_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        wr_val;
    logic [1:0]  wr_q;
    logic [15:0] wr_size;
    logic        rd_val;
    logic [1:0]  rd_q;
    logic        exp_rdy;
    logic [1:0]  chk_q;
    logic [3:0]  exp_lvl;
    logic [15:0] exp_size;
    logic [3:0]  exp_sval;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input string n, input logic wv, input logic [1:0] wq,
                              input logic [15:0] ws, input logic rv, input logic [1:0] rq,
                              input logic rdy, input logic [1:0] cq, input logic [3:0] lvl,
                              input logic [15:0] sz, input logic [3:0] sv);
    vec_t v;
    v.name = n; v.wr_val = wv; v.wr_q = wq; v.wr_size = ws; v.rd_val = rv; v.rd_q = rq;
    v.exp_rdy = rdy; v.chk_q = cq; v.exp_lvl = lvl; v.exp_size = sz; v.exp_sval = sv;
    return v;
  endfunction

  task automatic idle_inputs();
    wr_val_i = 1'b0; wr_q_i = '0; wr_size_i = '0;
    read_val_i = 1'b0; read_i = '0;
  endtask

  task automatic do_write(input logic [1:0] q, input logic [15:0] sz);
    @(negedge clk_i);
    wr_q_i = q; wr_size_i = sz; wr_val_i = 1'b1;
    @(posedge clk_i); #1;
    wr_val_i = 1'b0;
  endtask

  task automatic do_pop(input logic [1:0] q);
    @(negedge clk_i);
    read_i = q; read_val_i = 1'b1;
    @(posedge clk_i); #1;
    read_val_i = 1'b0;
  endtask

  int          deficit [NQ];
  int          popped_sum;
  int          exp_drop0;
  logic [15:0] head;

  initial begin
    vecs[0]  = mk("wr2_100",     1, 2, 100, 0, 0, 1, 2, 1, 100, 4'b0100);
    vecs[1]  = mk("wr2_200",     1, 2, 200, 0, 0, 1, 2, 2, 100, 4'b0100);
    vecs[2]  = mk("wr2_300",     1, 2, 300, 0, 0, 1, 2, 3, 100, 4'b0100);
    vecs[3]  = mk("pop2_a",      0, 0,   0, 1, 2, 1, 2, 2, 200, 4'b0100);
    vecs[4]  = mk("pop2_b",      0, 0,   0, 1, 2, 1, 2, 1, 300, 4'b0100);
    vecs[5]  = mk("pop2_c",      0, 0,   0, 1, 2, 1, 2, 0,   0, 4'b0000);
    for (int i = 0; i < 8; i++)
      vecs[6+i] = mk($sformatf("fill0_%0d", i), 1, 0, 16'(10*(i+1)), 0, 0, 1, 0,
                     4'(i+1), 16'd10, 4'b0001);
    vecs[14] = mk("wr0_full",    1, 0,  64, 0, 0, 0, 0, 8,  10, 4'b0001);
    vecs[15] = mk("wr1_500",     1, 1, 500, 0, 0, 1, 1, 1, 500, 4'b0011);
    vecs[16] = mk("wr1_pop1",    1, 1, 700, 1, 1, 1, 1, 1, 700, 4'b0011);
    vecs[17] = mk("wr3_zero",    1, 3,   0, 0, 0, 1, 3, 0,   0, 4'b0011);
    vecs[18] = mk("pop3_empty",  0, 0,   0, 1, 3, 1, 3, 0,   0, 4'b0011);
    vecs[19] = mk("wr0full_pop0",1, 0,  99, 1, 0, 0, 0, 7,  20, 4'b0011);
    vecs[20] = mk("wr3_pop1",    1, 3,  55, 1, 1, 1, 3, 1,  55, 4'b1001);

    idle_inputs();
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_size_val", 32'(size_val_o), 32'd0);
    check("rst_level",    32'(level_o),    32'd0);
    check("rst_size",     32'(size_o[0] | size_o[1] | size_o[2] | size_o[3]), 32'd0);
    check("rst_drop",     32'(drop_cnt_o[0] | drop_cnt_o[1] | drop_cnt_o[2] | drop_cnt_o[3]), 32'd0);
    check("rst_ready",    32'(wr_ready_o), 32'd1);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      wr_val_i = vecs[i].wr_val; wr_q_i = vecs[i].wr_q; wr_size_i = vecs[i].wr_size;
      read_val_i = vecs[i].rd_val; read_i = vecs[i].rd_q;
      #1;
      if (vecs[i].wr_val) check({vecs[i].name, "_rdy"}, 32'(wr_ready_o), 32'(vecs[i].exp_rdy));
      @(posedge clk_i); #1;
      check({vecs[i].name, "_lvl"},  32'(level_o[vecs[i].chk_q]), 32'(vecs[i].exp_lvl));
      check({vecs[i].name, "_size"}, 32'(size_o[vecs[i].chk_q]),  32'(vecs[i].exp_size));
      check({vecs[i].name, "_sval"}, 32'(size_val_o),             32'(vecs[i].exp_sval));
    end
    idle_inputs();

`ifdef PKT_QS_DROP_CNT_EN
    exp_drop0 = 2;
`else
    exp_drop0 = 0;
`endif
    check("drop_cnt_q0", 32'(drop_cnt_o[0]), 32'(exp_drop0));
    check("drop_cnt_q3", 32'(drop_cnt_o[3]), 32'd0);

    // Half-fill every queue, then reset between edges.
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 4; k++) do_write(2'(q), 16'(q*100 + k + 1));
    check("half_lvl1", 32'(level_o[1]), 32'd4);
    check("half_lvl0", 32'(level_o[0]), 32'd8);
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("midrst_sval",  32'(size_val_o), 32'd0);
    check("midrst_level", 32'(level_o),    32'd0);
    check("midrst_drop",  32'(drop_cnt_o[0]), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Drain with a deficit round-robin scheduler, quantum 500.
    do_write(0, 600); do_write(1, 300); do_write(2, 1500); do_write(3, 200);
    check("drr_loaded", 32'(size_val_o), 32'b1111);
    popped_sum = 0;
    for (int q = 0; q < NQ; q++) deficit[q] = 0;
    for (int rnd = 0; rnd < 16 && size_val_o != '0; rnd++) begin
      for (int q = 0; q < NQ; q++) begin
        if (!size_val_o[q]) begin
          deficit[q] = 0;
          continue;
        end
        deficit[q] += 500;
        for (int g = 0; g < 8 && size_val_o[q] && (int'(size_o[q]) <= deficit[q]); g++) begin
          head = size_o[q];
          deficit[q] -= int'(head);
          popped_sum += int'(head);
          do_pop(2'(q));
        end
        if (!size_val_o[q]) deficit[q] = 0;
      end
    end
    check("drr_sval_empty", 32'(size_val_o), 32'd0);
    check("drr_level",      32'(level_o),    32'd0);
    check("drr_total",      32'(popped_sum), 32'd2600);

    // Consecutive-cycle pops of one queue.
    do_write(1, 11); do_write(1, 22); do_write(1, 33);
    @(negedge clk_i);
    read_i = 1; read_val_i = 1'b1;
    @(posedge clk_i); #1;
    check("b2b_pop_a", 32'(size_o[1]), 32'd22);
    @(posedge clk_i); #1;
    check("b2b_pop_b", 32'(size_o[1]), 32'd33);
    @(posedge clk_i); #1;
    read_val_i = 1'b0;
    check("b2b_pop_c", 32'(size_o[1]), 32'd0);
    check("b2b_sval",  32'(size_val_o[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
